fighter_anim_ctrl: RTL and testbench

FIGHTER_ANIM_CTRL -- requirements
Module: fighter_anim_ctrl

---
 rtl/fighter_anim_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fighter_anim_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fighter_anim_ctrl.sv
// fighter_anim_ctrl: animation/attack sequencer for one fighter sprite.
// Drives the sprite select, hitbox-valid and busy/done handshake from
// crouch/punch requests, counting attack, recovery and hit-stun time in
// video frames (frame_tick).
// Optional feature: define FIGHTER_HITSTUN_EN to let `hit` force the STUN
// state; without it `hit` is ignored and STUN is unreachable.
module fighter_anim_ctrl #(
  parameter int unsigned ATK_FRAMES   = 12,
  parameter int unsigned ACTIVE_START = 3,
  parameter int unsigned ACTIVE_END   = 6,
  parameter int unsigned REC_FRAMES   = 8,
  parameter int unsigned STUN_FRAMES  = 16
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       crouch_req,
  input  logic       punch_req,
  input  logic       hit,
  output logic [2:0] sprite_sel,
  output logic       attack_active,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CROUCH  = 3'd1,
    PUNCH   = 3'd2,
    CPUNCH  = 3'd3,
    RECOVER = 3'd4,
    STUN    = 3'd5
  } state_t;

  localparam logic [5:0] ATK_LAST  = 6'(ATK_FRAMES - 1);
  localparam logic [5:0] REC_LAST  = 6'(REC_FRAMES - 1);
  localparam logic [5:0] STUN_LAST = 6'(STUN_FRAMES - 1);
  localparam logic [5:0] ACT_LO    = 6'(ACTIVE_START);
  localparam logic [5:0] ACT_HI    = 6'(ACTIVE_END);

  state_t     state, state_n;
  logic [5:0] cnt, cnt_n, cnt_inc;
  logic       low, low_n;
  logic       punch_prev;
  logic       punch_edge;
  logic       stun_req;

  logic [2:0] sprite_d;
  logic       attack_d;
  logic       busy_d;
  logic       done_d;

`ifdef FIGHTER_HITSTUN_EN
  assign stun_req = hit;
`else
  logic unused_hit;
  assign unused_hit = hit;
  assign stun_req   = 1'b0;
`endif

  assign punch_edge = punch_req & ~punch_prev;
  assign cnt_inc    = (cnt == '1) ? cnt : cnt + 6'd1;

  // State, frame counter, stance flag and punch history registers
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      low        <= 1'b0;
      punch_prev <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      low        <= low_n;
      punch_prev <= punch_req;
    end
  end

  // Next-state, next-count and stance decisions
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    low_n   = low;
    if (stun_req) begin
      state_n = STUN;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (punch_edge) begin
            state_n = crouch_req ? CPUNCH : PUNCH;
            low_n   = crouch_req;
            cnt_n   = '0;
          end else if (crouch_req) begin
            state_n = CROUCH;
            cnt_n   = '0;
          end
        end
        CROUCH: begin
          if (punch_edge) begin
            state_n = CPUNCH;
            low_n   = 1'b1;
            cnt_n   = '0;
          end else if (!crouch_req) begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        PUNCH, CPUNCH: begin
          if (frame_tick) begin
            if (cnt == ATK_LAST) begin
              state_n = RECOVER;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end
        end
        RECOVER: begin
          if (frame_tick) begin
            if (cnt == REC_LAST) begin
              state_n = crouch_req ? CROUCH : IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end
        end
        STUN: begin
          if (frame_tick) begin
            if (cnt == STUN_LAST) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          low_n   = 1'b0;
        end
      endcase
    end
  end

  // Output values decoded from the upcoming state so they can be registered
  // without adding a cycle of lag relative to the state register
  always_comb begin
    sprite_d = 3'd0;
    unique case (state_n)
      IDLE:    sprite_d = 3'd0;
      CROUCH:  sprite_d = 3'd1;
      PUNCH:   sprite_d = 3'd2;
      CPUNCH:  sprite_d = 3'd3;
      RECOVER: sprite_d = low_n ? 3'd1 : 3'd0;
      STUN:    sprite_d = 3'd4;
      default: sprite_d = 3'd0;
    endcase
    attack_d = ((state_n == PUNCH) || (state_n == CPUNCH)) &&
               (cnt_n >= ACT_LO) && (cnt_n <= ACT_HI);
    busy_d   = (state_n == PUNCH) || (state_n == CPUNCH) ||
               (state_n == RECOVER) || (state_n == STUN);
    done_d   = ((state == RECOVER) || (state == STUN)) && (state_n != state);
  end

  // Output registers
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      sprite_sel    <= '0;
      attack_active <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      sprite_sel    <= sprite_d;
      attack_active <= attack_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Testbench for fighter_anim_ctrl: directed scenarios followed by random
// stimulus, checked through an expectation queue against an activity-level
// reference model. Honours FIGHTER_HITSTUN_EN the same way the design does.
module tb_fighter_anim_ctrl;

  localparam int ATK = 12;
  localparam int AS  = 3;
  localparam int AE  = 6;
  localparam int REC = 8;
  localparam int STN = 16;

  localparam int A_NONE    = 0;
  localparam int A_ATTACK  = 1;
  localparam int A_RECOVER = 2;
  localparam int A_STUN    = 3;

  logic       vga_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       crouch_req = 1'b0;
  logic       punch_req = 1'b0;
  logic       hit = 1'b0;
  logic [2:0] sprite_sel;
  logic       attack_active;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [2:0] spr;
    logic       act;
    logic       bsy;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_printed = 0;
  int   cyc = 0;
  bit   started = 1'b0;
  bit   running = 1'b1;

  // Reference model: what the fighter is doing and how many frames of it
  // have elapsed.
  int m_act = A_NONE;
  int m_el = 0;
  bit m_crouch = 1'b0;
  bit m_low = 1'b0;
  bit m_prev = 1'b1;

  fighter_anim_ctrl #(
    .ATK_FRAMES  (ATK),
    .ACTIVE_START(AS),
    .ACTIVE_END  (AE),
    .REC_FRAMES  (REC),
    .STUN_FRAMES (STN)
  ) dut (
    .vga_clk      (vga_clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .crouch_req   (crouch_req),
    .punch_req    (punch_req),
    .hit          (hit),
    .sprite_sel   (sprite_sel),
    .attack_active(attack_active),
    .busy         (busy),
    .done         (done)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic exp_t model_step(input bit r, input bit c, input bit p,
                                      input bit h, input bit t);
    exp_t e;
    bit   edge_p;
    bit   dn;
    dn = 1'b0;
    if (r) begin
      m_act = A_NONE; m_el = 0; m_crouch = 1'b0; m_low = 1'b0; m_prev = 1'b1;
      e = '0;
      return e;
    end
    edge_p = p && !m_prev;
    m_prev = p;
`ifdef FIGHTER_HITSTUN_EN
    if (h) begin
      dn    = (m_act == A_RECOVER);
      m_act = A_STUN;
      m_el  = 0;
    end else
`endif
    begin
      case (m_act)
        A_NONE: begin
          if (edge_p) begin
            m_low = m_crouch || c;
            m_act = A_ATTACK;
            m_el  = 0;
          end else begin
            m_crouch = c;
          end
        end
        A_ATTACK: if (t) begin
          m_el++;
          if (m_el == ATK) begin m_act = A_RECOVER; m_el = 0; end
        end
        A_RECOVER: if (t) begin
          m_el++;
          if (m_el == REC) begin m_act = A_NONE; m_crouch = c; dn = 1'b1; end
        end
        default: if (t) begin
          m_el++;
          if (m_el == STN) begin m_act = A_NONE; m_crouch = 1'b0; dn = 1'b1; end
        end
      endcase
    end
    case (m_act)
      A_NONE:    e.spr = m_crouch ? 3'd1 : 3'd0;
      A_ATTACK:  e.spr = m_low ? 3'd3 : 3'd2;
      A_RECOVER: e.spr = m_low ? 3'd1 : 3'd0;
      default:   e.spr = 3'd4;
    endcase
    e.act = (m_act == A_ATTACK) && (m_el >= AS) && (m_el <= AE);
    e.bsy = (m_act != A_NONE);
    e.dn  = dn;
    return e;
  endfunction

  task automatic drive(input bit r, input bit c, input bit p, input bit h, input bit t);
    @(negedge vga_clk);
    Reset      = r;
    crouch_req = c;
    punch_req  = p;
    hit        = h;
    frame_tick = t;
    exp_q.push_back(model_step(r, c, p, h, t));
    started = 1'b1;
  endtask

  // n cycles with fixed levels; a frame_tick every `every` cycles
  task automatic run(input int n, input bit c, input bit p, input int every);
    for (int i = 0; i < n; i++)
      drive(1'b0, c, p, 1'b0, (i % every) == (every - 1));
  endtask

  // Monitor: compare every output update against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge vga_clk);
      #1;
      cyc++;
      if (running && started) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL no_expectation cycle %0d: output present with empty queue", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({sprite_sel, attack_active, busy, done} === e) begin
            n_pass++;
          end else if (n_printed < 40) begin
            n_printed++;
            $display("FAIL outputs cycle %0d: got spr=%0d act=%0b busy=%0b done=%0b, expected spr=%0d act=%0b busy=%0b done=%0b",
                     cyc, sprite_sel, attack_active, busy, done, e.spr, e.act, e.bsy, e.dn);
          end
        end
      end
    end
  end

  initial begin
    bit c_lvl, p_lvl;
    // reset held with punch high: the held punch must not start an attack
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    run(40, 1'b0, 1'b1, 4);
    // release, then punch edge coincident with a frame_tick; hold punch
    run(3, 1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run(130, 1'b0, 1'b1, 4);
    // crouch, crouch-punch, crouch held through recovery
    run(4, 1'b1, 1'b0, 4);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run(120, 1'b1, 1'b1, 3);
    run(4, 1'b0, 1'b0, 4);
    // reset in frame 5 of a punch while punch stays high
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run(20, 1'b0, 1'b1, 4);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run(30, 1'b0, 1'b1, 2);
    // hit during frame 4 of a crouch-punch
    run(3, 1'b1, 1'b0, 4);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run(16, 1'b1, 1'b1, 4);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run(120, 1'b0, 1'b0, 4);
    // random traffic
    c_lvl = 1'b0;
    p_lvl = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 19) == 0) c_lvl = ~c_lvl;
      if ($urandom_range(0, 9) == 0) p_lvl = ~p_lvl;
      drive($urandom_range(0, 399) == 0, c_lvl, p_lvl,
            $urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0);
    end
    @(posedge vga_clk);
    #2;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
